// File: rtl/inbuf_sync_filter.sv
// inbuf_sync_filter: conditions one asynchronous pad input for core logic.
//   A -> SYNC_STAGES-deep synchroniser -> glitch filter -> Z, plus RISE/FALL
//   edge pulses and a STABLE flag.
// Build option: define INBUF_FILTER_EN to enable the FILTER_CYCLES glitch
// filter. Without it, Z simply follows the synchroniser on EN cycles.
// Legal ranges: SYNC_STAGES 2..4, FILTER_CYCLES 1..255.
module inbuf_sync_filter #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic A,
  input  logic EN,
  output logic Z,
  output logic RISE,
  output logic FALL,
  output logic STABLE
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;
  logic                   z_q, z_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Synchroniser shifts every cycle, independent of EN.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], A};
    sync_out = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser, output level and edge-pulse registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      z_q    <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      z_q    <= z_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

`ifdef INBUF_FILTER_EN
  localparam int            CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Filter: a new level must be seen on FILTER_CYCLES consecutive EN cycles;
  // any reversion back to Z discards the partial count.
  always_comb begin
    z_d    = z_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (EN) begin
      if (sync_out == z_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        z_d    = sync_out;
        cnt_d  = '0;
        rise_d = sync_out;
        fall_d = ~sync_out;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Filter counter register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign STABLE = (sync_out == z_q);
`else
  // No filter: Z tracks the synchroniser on every EN cycle.
  always_comb begin
    z_d    = z_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (EN && (sync_out != z_q)) begin
      z_d    = sync_out;
      rise_d = sync_out;
      fall_d = ~sync_out;
    end
  end

  // FILTER_CYCLES has no effect in this build.
  logic unused_cfg;
  assign unused_cfg = (FILTER_CYCLES > 0);

  assign STABLE = 1'b1;
`endif

  assign Z    = z_q;
  assign RISE = rise_q;
  assign FALL = fall_q;

endmodule

// File: tb/tb_inbuf_sync_filter.sv
// Directed bench for inbuf_sync_filter; follows the INBUF_FILTER_EN build option.
module tb_inbuf_sync_filter;

`ifdef INBUF_FILTER_EN
  localparam int LAT  = 6;  // SYNC_STAGES + FILTER_CYCLES
  localparam int LAT1 = 3;  // SYNC_STAGES + 1 (FILTER_CYCLES=1)
`else
  localparam int LAT  = 3;  // SYNC_STAGES + 1
  localparam int LAT1 = 3;
`endif

  logic CLK = 1'b0;
  logic RSTN, A, A1, EN;
  logic Z, RISE, FALL, STABLE;
  logic Z1, RISE1, FALL1, STABLE1;

  int n_cmp = 0;
  int n_bad = 0;

  inbuf_sync_filter u_dut (
    .CLK(CLK), .RSTN(RSTN), .A(A), .EN(EN),
    .Z(Z), .RISE(RISE), .FALL(FALL), .STABLE(STABLE)
  );

  inbuf_sync_filter #(.FILTER_CYCLES(1)) u_dut1 (
    .CLK(CLK), .RSTN(RSTN), .A(A1), .EN(EN),
    .Z(Z1), .RISE(RISE1), .FALL(FALL1), .STABLE(STABLE1)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // A changed just before: Z must stay low through edge lat-1, rise on edge lat
  // with a single-cycle RISE.
  task automatic expect_rise(input string tag, input int lat);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk({tag, "_z_pre"}, Z, 1'b0);
      chk({tag, "_rise_pre"}, RISE, 1'b0);
    end
    tick();
    chk({tag, "_z"}, Z, 1'b1);
    chk({tag, "_rise"}, RISE, 1'b1);
    chk({tag, "_fall"}, FALL, 1'b0);
    tick();
    chk({tag, "_z_hold"}, Z, 1'b1);
    chk({tag, "_rise_end"}, RISE, 1'b0);
  endtask

  task automatic expect_fall(input string tag, input int lat);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk({tag, "_z_pre"}, Z, 1'b1);
      chk({tag, "_fall_pre"}, FALL, 1'b0);
    end
    tick();
    chk({tag, "_z"}, Z, 1'b0);
    chk({tag, "_fall"}, FALL, 1'b1);
    chk({tag, "_rise"}, RISE, 1'b0);
    tick();
    chk({tag, "_z_hold"}, Z, 1'b0);
    chk({tag, "_fall_end"}, FALL, 1'b0);
  endtask

  initial begin
    int nr, nf;
    RSTN = 1'b0; A = 1'b1; A1 = 1'b0; EN = 1'b1;

    // Reset held with A=1: outputs at reset value.
    #3;
    chk("rst_z_imm", Z, 1'b0);
    chk("rst_rise_imm", RISE, 1'b0);
    chk("rst_fall_imm", FALL, 1'b0);
    tick(); tick();
    chk("rst_z", Z, 1'b0);
    chk("rst_rise", RISE, 1'b0);
    chk("rst_fall", FALL, 1'b0);
    chk("rst_stable", STABLE, 1'b1);

    // Release between edges, A=1 held: full latency then one RISE.
    RSTN = 1'b1;
`ifdef INBUF_FILTER_EN
    tick(); tick(); tick();
    chk("lat_stable_pending", STABLE, 1'b0);
    tick(); tick(); tick();
    chk("lat_z", Z, 1'b1);
    chk("lat_rise", RISE, 1'b1);
    chk("lat_stable_done", STABLE, 1'b1);
    tick();
    chk("lat_rise_end", RISE, 1'b0);
`else
    expect_rise("lat", LAT);
    chk("lat_stable", STABLE, 1'b1);
`endif

    // Return to 0: one FALL.
    A = 1'b0;
    expect_fall("fall", LAT);

`ifdef INBUF_FILTER_EN
    // 3-cycle glitch is rejected.
    A = 1'b1;
    tick(); tick(); tick();
    A = 1'b0;
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (RISE) nr++;
      chk("glitch_z", Z, 1'b0);
    end
    chk("glitch_norise", (nr == 0), 1'b1);
    chk("glitch_stable", STABLE, 1'b1);

    // EN dropped at count 2 for 10 cycles; Z rises 2 EN-cycles after return.
    A = 1'b1;
    tick(); tick(); tick(); tick();
    EN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("engate_z_hold", Z, 1'b0);
      chk("engate_rise", RISE, 1'b0);
    end
    EN = 1'b1;
    tick();
    chk("engate_z_1", Z, 1'b0);
    tick();
    chk("engate_z_2", Z, 1'b1);
    chk("engate_rise_2", RISE, 1'b1);
    A = 1'b0;
    expect_fall("engate_fall", LAT);

    // Async reset with CNT=2: pending rise discarded, full latency restarts.
    A = 1'b1;
    tick(); tick(); tick(); tick();
    RSTN = 1'b0;
    #1;
    chk("midrst_z", Z, 1'b0);
    chk("midrst_rise", RISE, 1'b0);
    #1;
    RSTN = 1'b1;
    expect_rise("midrst_restart", LAT);
`else
    // EN low: Z holds even though sync chain has the new level.
    A = 1'b1;
    EN = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("engate_z_hold", Z, 1'b0);
      chk("engate_rise", RISE, 1'b0);
      chk("engate_stable", STABLE, 1'b1);
    end
    EN = 1'b1;
    tick();
    chk("engate_z", Z, 1'b1);
    chk("engate_rise_1", RISE, 1'b1);
    tick();
    chk("engate_rise_end", RISE, 1'b0);
`endif

    // Async reset with Z=1: Z drops at once, no pulse, then re-rises.
    A = 1'b1;
    tick();
    chk("rst1_z_before", Z, 1'b1);
    RSTN = 1'b0;
    #1;
    chk("rst1_z", Z, 1'b0);
    chk("rst1_fall", FALL, 1'b0);
    #1;
    RSTN = 1'b1;
    expect_rise("rst1_restart", LAT);
    A = 1'b0;
    expect_fall("rst1_fall_back", LAT);

`ifndef INBUF_FILTER_EN
    // One-cycle pulse passes straight through when unfiltered.
    A = 1'b1;
    tick();
    A = 1'b0;
    tick();
    chk("pass_z_pre", Z, 1'b0);
    tick();
    chk("pass_z", Z, 1'b1);
    chk("pass_rise", RISE, 1'b1);
    tick();
    chk("pass_z_end", Z, 1'b0);
    chk("pass_fall", FALL, 1'b1);
    chk("pass_stable", STABLE, 1'b1);
`endif

    // FILTER_CYCLES=1 instance: A1 0->1->0, each held 5 cycles.
    tick();
    chk("fc1_z_init", Z1, 1'b0);
    nr = 0; nf = 0;
    A1 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (RISE1) nr++;
      if (FALL1) nf++;
      if (i == LAT1 - 1) chk("fc1_z_pre", Z1, 1'b0);
      if (i == LAT1) begin
        chk("fc1_z_rise", Z1, 1'b1);
        chk("fc1_rise", RISE1, 1'b1);
      end
    end
    A1 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (RISE1) nr++;
      if (FALL1) nf++;
      if (i == LAT1 - 1) chk("fc1_z_hi", Z1, 1'b1);
      if (i == LAT1) begin
        chk("fc1_z_fall", Z1, 1'b0);
        chk("fc1_fall", FALL1, 1'b1);
      end
    end
    chk("fc1_one_rise", (nr == 1), 1'b1);
    chk("fc1_one_fall", (nf == 1), 1'b1);
    chk("fc1_stable", STABLE1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
